// File: rtl/mem_arbiter.sv
// Fetch/exec arbiter for the shared single-port BRAM. Exec has priority, a
// starvation counter forces periodic fetch grants, and a tag pipe routes read data back.
module mem_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [18:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ex_req,
    input  logic [18:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_wea,
    output logic        ex_gnt,
    output logic        ex_rvalid,
    output logic [31:0] ex_rdata,
    output logic        mem_enable,
    output logic [18:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wea,
    input  logic [31:0] mem_rdata,
    output logic [31:0] fetch_stall_cnt
);
    localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic { OWN_IF = 1'b0, OWN_EX = 1'b1 } owner_e;
    typedef struct packed {
        logic   vld;
        owner_e own;
    } tag_t;

    tag_t [RD_LAT-1:0] tag_pipe;
    tag_t              tag_in;
    logic [SW-1:0]     starve_q;
    logic [31:0]       stall_q;
    logic              fprio;
    logic              stalled;

    assign fprio   = (MAX_WAIT != 0) && (starve_q == SW'(MAX_WAIT)) && if_req;
    assign ex_gnt  = ex_req & ~fprio;
    assign if_gnt  = if_req & ~ex_gnt;
    assign stalled = if_req & ~if_gnt;

    // A fetch grant is always a read, so its write lanes stay quiet.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wea   = '0;
        if (ex_gnt) begin
            mem_addr  = ex_addr;
            mem_wdata = ex_wdata;
            mem_wea   = ex_wea;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    always_comb begin
        tag_in.vld = if_gnt | (ex_gnt & (ex_wea == 4'b0000));
        tag_in.own = ex_gnt ? OWN_EX : OWN_IF;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
            stall_q  <= '0;
        end else begin
            if (stalled) begin
                if (starve_q != SW'(MAX_WAIT))
                    starve_q <= starve_q + SW'(1);
            end else begin
                starve_q <= '0;
            end
            if (stalled && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign if_rvalid       = tag_pipe[RD_LAT-1].vld && (tag_pipe[RD_LAT-1].own == OWN_IF);
    assign ex_rvalid       = tag_pipe[RD_LAT-1].vld && (tag_pipe[RD_LAT-1].own == OWN_EX);
    assign if_rdata        = mem_rdata;
    assign ex_rdata        = mem_rdata;
    assign mem_enable      = 1'b1;
    assign fetch_stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: BRAM model, grant/port reference model feeding a response
// scoreboard, and a monitor that pops responses on every rvalid pulse.
module tb_mem_arbiter;
    localparam int RD_LAT = 2;
    localparam int MW     = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, ex_req;
    logic [18:0] if_addr, ex_addr;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_wea;
    logic        if_gnt, ex_gnt, if_rvalid, ex_rvalid, mem_enable;
    logic [31:0] if_rdata, ex_rdata, mem_wdata, mem_rdata, fetch_stall_cnt;
    logic [18:0] mem_addr;
    logic [3:0]  mem_wea;

    // second instance with strict exec priority
    logic        z_if_req, z_ex_req;
    logic        z_if_gnt, z_ex_gnt, z_if_rvalid, z_ex_rvalid, z_mem_enable;
    logic [31:0] z_if_rdata, z_ex_rdata, z_mem_wdata, z_fetch_stall_cnt;
    logic [31:0] z_mem_rdata = '0;
    logic [18:0] z_mem_addr;
    logic [3:0]  z_mem_wea;

    always #5 clk = ~clk;

    mem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MW)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ex_req(ex_req), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_wea(ex_wea),
        .ex_gnt(ex_gnt), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wea(mem_wea), .mem_rdata(mem_rdata), .fetch_stall_cnt(fetch_stall_cnt)
    );

    mem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rstn(rstn),
        .if_req(z_if_req), .if_addr(19'h1), .if_gnt(z_if_gnt),
        .if_rvalid(z_if_rvalid), .if_rdata(z_if_rdata),
        .ex_req(z_ex_req), .ex_addr(19'h2), .ex_wdata(32'h0), .ex_wea(4'h0),
        .ex_gnt(z_ex_gnt), .ex_rvalid(z_ex_rvalid), .ex_rdata(z_ex_rdata),
        .mem_enable(z_mem_enable), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_wea(z_mem_wea), .mem_rdata(z_mem_rdata), .fetch_stall_cnt(z_fetch_stall_cnt)
    );

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h10) return 32'hDEAD_BEEF;
        if (i == 'h30) return 32'hAAAA_AAAA;
        return 32'h1000_0000 ^ (i * 32'h9E37_79B9);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: read-first, RD_LAT register stages to mem_rdata
    logic [31:0] bram [256];
    logic [31:0] rd_q [RD_LAT];
    bit          bram_init = 0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < 256; i++) bram[i] = init_word(i);
            bram_init = 1;
        end
        for (int i = RD_LAT - 1; i > 0; i--) rd_q[i] <= rd_q[i-1];
        rd_q[0] <= bram[mem_addr[7:0]];
        for (int b = 0; b < 4; b++)
            if (mem_wea[b]) bram[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
    assign mem_rdata = rd_q[RD_LAT-1];

    // Reference model: grant rules, expected memory contents, expected responses
    typedef struct {
        bit          ex;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t        q[$];
    logic [31:0] ref_mem [256];
    bit          ref_init = 0;
    int          denied = 0;
    logic [31:0] stall_exp = '0;
    bit          m_if_gnt = 0, m_ex_gnt = 0;

    always @(negedge clk) begin
        bit          fp, e_if, e_ex;
        logic [54:0] port_exp;
        exp_t        e;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            ref_init = 1;
        end
        if (!rstn) begin
            q.delete();
            denied = 0;
            stall_exp = '0;
            m_if_gnt = 0;
            m_ex_gnt = 0;
        end else begin
            // fetch forces a win after MW consecutive denied cycles
            fp   = (MW != 0) && (denied >= MW) && if_req;
            e_ex = ex_req && !fp;
            e_if = if_req && !e_ex;
            chk("grant", {if_gnt, ex_gnt}, {e_if, e_ex});
            port_exp = '0;
            if (e_ex)      port_exp = {ex_addr, ex_wdata, ex_wea};
            else if (e_if) port_exp = {if_addr, 32'h0, 4'h0};
            chk("mem_port", {mem_enable, mem_addr, mem_wdata, mem_wea}, {1'b1, port_exp});
            chk("stall_cnt", fetch_stall_cnt, stall_exp);
            if (if_req && !e_if) begin
                denied++;
                if (stall_exp != 32'hFFFF_FFFF) stall_exp++;
            end else begin
                denied = 0;
            end
            if (e_ex && ex_wea != 0) begin
                for (int b = 0; b < 4; b++)
                    if (ex_wea[b]) ref_mem[ex_addr[7:0]][8*b +: 8] = ex_wdata[8*b +: 8];
            end else if (e_ex || e_if) begin
                e.ex   = e_ex;
                e.data = ref_mem[e_ex ? ex_addr[7:0] : if_addr[7:0]];
                e.due  = cyc + RD_LAT;
                q.push_back(e);
            end
            m_if_gnt = e_if;
            m_ex_gnt = e_ex;
        end
    end

    // Monitor: every rvalid pulse must match the oldest outstanding read
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            chk("rvalid_in_reset", {if_rvalid, ex_rvalid}, 2'b00);
        end else if (if_rvalid || ex_rvalid) begin
            if (q.size() == 0) begin
                chk("spurious_rvalid", {if_rvalid, ex_rvalid}, 2'b00);
            end else begin
                e = q.pop_front();
                chk("rv_owner", {if_rvalid, ex_rvalid}, e.ex ? 2'b01 : 2'b10);
                chk("rv_data", e.ex ? ex_rdata : if_rdata, e.data);
                chk("rv_latency", cyc, e.due);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("missing_rvalid", 1'b0, 1'b1);
        end
    end

    task automatic step(input logic ir, input logic [18:0] ia, input logic er,
                        input logic [18:0] ea, input logic [31:0] wd, input logic [3:0] we);
        if_req = ir; if_addr = ia;
        ex_req = er; ex_addr = ea; ex_wdata = wd; ex_wea = we;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [18:0] ea;
        rstn = 1'b0;
        if_req = 0; if_addr = '0; ex_req = 0; ex_addr = '0; ex_wdata = '0; ex_wea = '0;
        z_if_req = 0; z_ex_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", fetch_stall_cnt, 32'h0);
        chk("reset_rvalid", {if_rvalid, ex_rvalid}, 2'b00);
        rstn = 1'b1;

        // single fetch read of preloaded word
        step(1'b1, 19'h10, 1'b0, '0, '0, '0);
        idle(4);

        // conflict: exec wins, fetch follows
        step(1'b1, 19'h14, 1'b1, 19'h20, '0, '0);
        step(1'b1, 19'h14, 1'b0, '0, '0, '0);
        idle(4);

        // starvation: fetch wins in cycles 4 and 9 only
        ea = 19'h40;
        for (int k = 0; k < 12; k++) begin
            if_req = 1'b1; if_addr = 19'h50 + 19'(k);
            ex_req = 1'b1; ex_addr = ea; ex_wdata = '0; ex_wea = '0;
            #3;
            chk("starve_if_gnt", if_gnt, (k == 4 || k == 9));
            @(posedge clk); #1;
            if (!(k == 4 || k == 9)) ea = ea + 19'd1;
        end
        idle(5);

        // write-then-read of the same word
        step(1'b0, '0, 1'b1, 19'h30, 32'h1234_5678, 4'b0011);
        step(1'b0, '0, 1'b1, 19'h30, '0, '0);
        idle(4);

        // reset mid-flight discards the outstanding exec read
        step(1'b0, '0, 1'b1, 19'h08, '0, '0);
        if_req = 0; ex_req = 0;
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_stall", fetch_stall_cnt, 32'h0);
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;
        idle(5);
        chk("post_rst_stall", fetch_stall_cnt, 32'h0);

        // stall counter saturation
        if_req = 1'b1; if_addr = 19'h11; ex_req = 1'b1; ex_addr = 19'h12; ex_wea = '0;
        #1;
        force dut.stall_q = 32'hFFFF_FFFE;
        stall_exp = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        @(posedge clk); #1;
        step(1'b1, 19'h11, 1'b1, 19'h13, '0, '0);
        step(1'b1, 19'h11, 1'b1, 19'h14, '0, '0);
        step(1'b1, 19'h11, 1'b0, '0, '0, '0);
        chk("stall_saturated", fetch_stall_cnt, 32'hFFFF_FFFF);
        idle(4);

        // strict exec priority instance
        for (int k = 0; k < 20; k++) begin
            z_if_req = 1'b1; z_ex_req = 1'b1;
            #3;
            chk("mw0_if_gnt", {z_if_gnt, z_ex_gnt}, 2'b01);
            @(posedge clk); #1;
        end
        z_ex_req = 1'b0;
        #3;
        chk("mw0_if_alone", {z_if_gnt, z_ex_gnt}, 2'b10);
        @(posedge clk); #1;
        z_if_req = 1'b0;

        // randomized traffic, obeying hold-until-granted
        for (int k = 0; k < 400; k++) begin
            if (!if_req || m_if_gnt) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = 19'($urandom_range(0, 63));
            end
            if (!ex_req || m_ex_gnt) begin
                ex_req   = ($urandom_range(0, 99) < 60);
                ex_addr  = 19'($urandom_range(0, 63));
                ex_wdata = $urandom;
                ex_wea   = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            @(posedge clk); #1;
        end
        idle(RD_LAT + 4);
        chk("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
